// File: rtl/switch_count_display_ctrl.sv
// ---------------------------------------------------------------------------
// switch_count_display_ctrl
//
// Manual-count path from a raw sliding switch to a multiplexed seven-segment
// display. The switch is synchronised and debounced. Each debounced
// down-transition (1->0) produces one count_pulse and one increment of a
// DIGITS-wide BCD counter. A round-robin scheduler time-shares one segment
// bus across the digit enables.
//
// Ports:
//   clk             system clock
//   reset_n         asynchronous active-low reset
//   sliding_switch  raw asynchronous switch level (up=1, down=0)
//   clear           synchronous clear of the count
//   count_pulse     one-cycle strobe on each accepted increment
//   bcd_count       BCD count, digit 0 in [3:0]
//   digit_en        one-hot active-low digit select
//   encoded_count   active-low segments (bit0=a .. bit6=g) for the selected digit
// ---------------------------------------------------------------------------
module switch_count_display_ctrl #(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCAN_CYCLES     = 50000,
  parameter int BLANK_LZ        = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sliding_switch,
  input  logic                clear,
  output logic                count_pulse,
  output logic [4*DIGITS-1:0] bcd_count,
  output logic [DIGITS-1:0]   digit_en,
  output logic [6:0]          encoded_count
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int TMR_W = $clog2(SCAN_CYCLES);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCAN_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] k);
    next_idx = (k == IDX_LAST) ? '0 : k + 1'b1;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic                sync1_q, sync2_q;
  logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
  logic                db_lvl_q, db_lvl_d;
  logic                db_lvl_dly_q;
  logic                pulse_q, pulse_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, bcd_inc;
  logic [IDX_W-1:0]    idx_q, idx_d, show_idx;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                last_d;
  logic [DIGITS-1:0]   en_q, en_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   blank;
  logic [3:0]          dig [DIGITS];
  logic                carry;
  logic                higher_zero;

  // -------------------------------------------------------------------------
  // Debouncer: counter only runs while the synchronised level disagrees with
  // the debounced level; any agreeing cycle restarts the qualification.
  // -------------------------------------------------------------------------
  always_comb begin
    db_cnt_d = '0;
    db_lvl_d = db_lvl_q;
    if (sync2_q != db_lvl_q) begin
      if (db_cnt_q == DB_LAST) db_lvl_d = sync2_q;
      else                     db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Falling edge of the debounced level, seen one cycle after it updates.
  assign pulse_d = db_lvl_dly_q & ~db_lvl_q;

  // -------------------------------------------------------------------------
  // BCD increment with ripple carry across digits
  // -------------------------------------------------------------------------
  always_comb begin
    bcd_inc = bcd_q;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (bcd_q[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Clear wins over a simultaneous increment.
  always_comb begin
    bcd_d = bcd_q;
    if (clear)        bcd_d = '0;
    else if (pulse_q) bcd_d = bcd_inc;
  end

  // -------------------------------------------------------------------------
  // Leading-zero blanking: digit k>0 blanks when it and every higher digit
  // are zero. Digit 0 is always shown.
  // -------------------------------------------------------------------------
  always_comb begin
    blank       = '0;
    higher_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      higher_zero = higher_zero & (bcd_q[4*i +: 4] == 4'd0);
      if (i > 0 && BLANK_LZ != 0) blank[i] = higher_zero;
    end
  end

  always_comb begin
    for (int i = 0; i < DIGITS; i++) dig[i] = bcd_q[4*i +: 4];
  end

  // -------------------------------------------------------------------------
  // Scan scheduler. Outputs are registered from the next state so they line
  // up with the slot/timer they describe. On the last cycle of a slot all
  // enables are off while the segments already carry the next digit, so the
  // bus settles before the next digit is enabled.
  // -------------------------------------------------------------------------
  always_comb begin
    tmr_d = tmr_q + 1'b1;
    idx_d = idx_q;
    if (tmr_q == TMR_LAST) begin
      tmr_d = '0;
      idx_d = next_idx(idx_q);
    end
    last_d   = (tmr_d == TMR_LAST);
    show_idx = last_d ? next_idx(idx_d) : idx_d;
    en_d     = last_d ? '1 : ~(DIGITS'(1) << idx_d);
    seg_d    = blank[show_idx] ? 7'b1111111 : seg7(dig[show_idx]);
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      db_cnt_q     <= '0;
      db_lvl_q     <= 1'b1;
      db_lvl_dly_q <= 1'b1;
      pulse_q      <= 1'b0;
      bcd_q        <= '0;
      idx_q        <= '0;
      tmr_q        <= '0;
      en_q         <= ~DIGITS'(1);
      seg_q        <= 7'b1000000;
    end else begin
      sync1_q      <= sliding_switch;
      sync2_q      <= sync1_q;
      db_cnt_q     <= db_cnt_d;
      db_lvl_q     <= db_lvl_d;
      db_lvl_dly_q <= db_lvl_q;
      pulse_q      <= pulse_d;
      bcd_q        <= bcd_d;
      idx_q        <= idx_d;
      tmr_q        <= tmr_d;
      en_q         <= en_d;
      seg_q        <= seg_d;
    end
  end

  assign count_pulse   = pulse_q;
  assign bcd_count     = bcd_q;
  assign digit_en      = en_q;
  assign encoded_count = seg_q;

endmodule

// File: tb/tb_switch_count_display_ctrl.sv
// ---------------------------------------------------------------------------
// Directed testbench for switch_count_display_ctrl
// (DIGITS=2, DEBOUNCE_CYCLES=4, SCAN_CYCLES=3, BLANK_LZ=1).
// ---------------------------------------------------------------------------
module tb_switch_count_display_ctrl;

  logic       clk;
  logic       reset_n;
  logic       sliding_switch;
  logic       clear;
  logic       count_pulse;
  logic [7:0] bcd_count;
  logic [1:0] digit_en;
  logic [6:0] encoded_count;

  int n_cmp   = 0;
  int n_err   = 0;
  int n_pulse = 0;

  switch_count_display_ctrl #(
    .DIGITS          (2),
    .DEBOUNCE_CYCLES (4),
    .SCAN_CYCLES     (3),
    .BLANK_LZ        (1)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sliding_switch (sliding_switch),
    .clear          (clear),
    .count_pulse    (count_pulse),
    .bcd_count      (bcd_count),
    .digit_en       (digit_en),
    .encoded_count  (encoded_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (count_pulse === 1'b1) n_pulse++;
  endtask

  task automatic wait_en(input logic [1:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      tick();
      if (digit_en == v) ok = 1'b1;
    end
  endtask

  // One accepted down-transition: pulse after 7 cycles, count after 8,
  // then back up long enough for the debouncer to settle at 1.
  task automatic press();
    sliding_switch = 1'b0;
    repeat (10) tick();
    sliding_switch = 1'b1;
    repeat (8) tick();
  endtask

  // Scan sequence after reset release (hand-derived, 3-cycle slots).
  logic [1:0] en_tab  [6] = '{2'b10, 2'b11, 2'b01, 2'b01, 2'b11, 2'b10};
  logic [6:0] seg_tab [6] = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40};

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit ok;
    bit found;
    int first_p;
    int base;

    reset_n        = 1'b0;
    sliding_switch = 1'b1;
    clear          = 1'b0;

    // 1. reset values, then idle scan with switch up
    #12;
    chk("rst_pulse", count_pulse, 1'b0);
    chk("rst_bcd", bcd_count, 8'h00);
    chk("rst_en", digit_en, 2'b10);
    chk("rst_seg", encoded_count, 7'h40);
    @(posedge clk);
    #3 reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("t1_en%0d", k), digit_en, en_tab[k]);
      chk($sformatf("t1_seg%0d", k), encoded_count, seg_tab[k]);
    end
    repeat (14) tick();
    chk("t1_no_pulse", n_pulse, 0);
    chk("t1_bcd", bcd_count, 8'h00);

    // 2. single down-transition: pulse 7 cycles after the input edge
    n_pulse = 0;
    first_p = 0;
    sliding_switch = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (count_pulse === 1'b1 && first_p == 0) first_p = k;
      if (k == 7) chk("t2_bcd_at_pulse", bcd_count, 8'h00);
      if (k == 8) chk("t2_bcd_after", bcd_count, 8'h01);
    end
    chk("t2_pulse_cycle", first_p, 7);
    chk("t2_pulse_cnt", n_pulse, 1);
    sliding_switch = 1'b1;
    repeat (10) tick();
    chk("t2_up_no_count", n_pulse, 1);
    chk("t2_bcd_up", bcd_count, 8'h01);
    wait_en(2'b10, ok);
    chk("t2_wait_d0", ok, 1'b1);
    chk("t2_seg_d0", encoded_count, 7'h79);
    wait_en(2'b01, ok);
    chk("t2_wait_d1", ok, 1'b1);
    chk("t2_seg_d1_blank", encoded_count, 7'h7F);

    // 3. 3-cycle glitches are rejected
    n_pulse = 0;
    for (int r = 0; r < 5; r++) begin
      sliding_switch = 1'b0;
      repeat (3) tick();
      sliding_switch = 1'b1;
      repeat (3) tick();
    end
    repeat (10) tick();
    chk("t3_no_pulse", n_pulse, 0);
    chk("t3_bcd", bcd_count, 8'h01);

    // 4. BCD carry and wrap
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t4_clear", bcd_count, 8'h00);
    n_pulse = 0;
    repeat (9) press();
    chk("t4_bcd9", bcd_count, 8'h09);
    press();
    chk("t4_bcd10", bcd_count, 8'h10);
    wait_en(2'b01, ok);
    chk("t4_wait_d1", ok, 1'b1);
    chk("t4_seg_d1", encoded_count, 7'h79);
    wait_en(2'b10, ok);
    chk("t4_wait_d0", ok, 1'b1);
    chk("t4_seg_d0", encoded_count, 7'h40);
    repeat (89) press();
    chk("t4_bcd99", bcd_count, 8'h99);
    press();
    chk("t4_wrap", bcd_count, 8'h00);
    chk("t4_pulses", n_pulse, 100);

    // 5. clear coincident with count_pulse
    repeat (42) press();
    chk("t5_bcd42", bcd_count, 8'h42);
    sliding_switch = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (count_pulse === 1'b1) found = 1'b1;
    end
    chk("t5_pulse_seen", found, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_cleared", bcd_count, 8'h00);
    chk("t5_pulse_one", count_pulse, 1'b0);
    repeat (3) tick();
    sliding_switch = 1'b1;
    repeat (8) tick();
    chk("t5_bcd_hold", bcd_count, 8'h00);

    // 6. reset mid-debounce during slot 1
    repeat (3) press();
    chk("t6_bcd3", bcd_count, 8'h03);
    wait_en(2'b11, ok);
    chk("t6_wait_blank", ok, 1'b1);
    wait_en(2'b10, ok);
    chk("t6_wait_d0", ok, 1'b1);
    sliding_switch = 1'b0;
    repeat (4) tick();
    chk("t6_slot1", digit_en, 2'b01);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_pulse", count_pulse, 1'b0);
    chk("t6_rst_bcd", bcd_count, 8'h00);
    chk("t6_rst_en", digit_en, 2'b10);
    chk("t6_rst_seg", encoded_count, 7'h40);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    base    = n_pulse;
    first_p = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (count_pulse === 1'b1 && first_p == 0) first_p = k;
    end
    chk("t6_pulse_cycle", first_p, 7);
    chk("t6_pulse_cnt", n_pulse - base, 1);
    chk("t6_bcd", bcd_count, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
